fft_writeback_ctrl: RTL and testbench
=====================================

Name: fft_writeback_ctrl

Overview:
- Write-back end of the FFT memory path: takes NUM_FFTS parallel lanes of FFT results and scatters them back into the DIMENSION^3 grid memory (DATABASE).
- Each beat from the FFT engines is one sample index k along the active transform dimension for NUM_FFTS adjacent lines.
- Generates per-lane write enables and write addresses, counts the pass, and pulses done once all D*D lines have been written.

Parameters:
- DIMENSION, 16, grid edge length D; power of 2, >= NUM_FFTS.
- NUM_FFTS, 4, parallel FFT lanes; power of 2, divides DIMENSION.
- DATA_REAL_WIDTH, 32, real field is DATA_REAL_WIDTH+1 bits.
- DATA_IMAG_WIDTH, 32, imag field is DATA_IMAG_WIDTH+1 bits.
- ADDR_WIDTH, 3*$clog2(DIMENSION), grid word address width (12 at defaults).

Ports:
- clk, input, 1, single clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, begin a pass; FFT_dim is sampled on this cycle.
- FFT_dim, input, 3, one-hot: 1=x, 2=y, 4=z.
- FFTData_valid, input, 1, all lanes carry a valid sample this cycle.
- FFTData_in, input, NUM_FFTS*(DATA_REAL_WIDTH+DATA_IMAG_WIDTH+2), lane l occupies slice l; {real, imag}, real in the MSBs.
- DATABASE_wren, output, NUM_FFTS, per-lane write enable.
- DATABASE_writeAddress, output, NUM_FFTS*ADDR_WIDTH, per-lane grid address.
- DATABASE_dataIn, output, same width as FFTData_in, registered lane data.
- busy, output, 1, high from the cycle after an accepted start through the done cycle.
- done, output, 1, one-cycle pulse at the end of a pass.
- err, output, 1, sticky protocol error; cleared only by rst.

Behaviour:
- Reset: all outputs 0; state IDLE; counters k=0, grp=0; latched dim=0.
- States:
  - IDLE: start with a valid one-hot FFT_dim latches dim, clears k and grp, and moves to RUN.
  - RUN: each FFTData_valid beat writes, then advances the counters.
  - DONE: lasts one cycle, then returns to IDLE.
- Counters:
  - k runs 0..D-1 and increments on every valid beat.
  - When k wraps from D-1 to 0, grp increments (grp range 0..D*D/NUM_FFTS-1).
  - A pass is D*D*D/NUM_FFTS beats (1024 at defaults).
- Address mapping:
  - Line index for lane l: line = grp*NUM_FFTS + l; define a = line mod D, b = line / D.
  - Grid address = x + y*D + z*D*D.
  - dim x: x=k, y=a, z=b. dim y: x=a, y=k, z=b. dim z: x=a, y=b, z=k.
- Latency and write handshake:
  - For a valid beat in RUN at cycle t, wren (all lanes), address and data are registered and presented at cycle t+1.
  - There is no backpressure; the memory accepts one write per lane per cycle.
- Done timing: the last beat (k=D-1, grp=max) moves the FSM to DONE. done=1 and busy=1 in the same cycle as that final write's wren; busy=0 the cycle after.
- Gaps: FFTData_valid=0 during RUN gives wren=0 and holds the counters; gaps of any length are legal.
- Error conditions (all set err):
  - start with FFT_dim=0 or multi-hot: start ignored, stay IDLE.
  - start while in RUN or DONE: start ignored, pass continues unaffected.
  - FFTData_valid while in IDLE: data dropped, wren=0.
- Simultaneous events:
  - start and FFTData_valid in the same IDLE cycle: start accepted, the beat is dropped, err set.
  - Next start in the DONE cycle: ignored, err set.
- Reset mid-pass: in the next cycle all outputs are 0, state IDLE, and no partial write is completed.

Optional Feature:
- Macro: FFT_WB_BITREV_EN.
- Defined: k is bit-reversed over $clog2(DIMENSION) bits before address mapping, so write-back absorbs bit-reversed FFT output order. Counting, done and err behaviour are unchanged.
- Undefined: k is used in natural order.

Test Plan:
- Reset then dim x pass, D=16, N=4. Beat k=0 gives addrs {0,16,32,48}; beat k=5 gives {5,21,37,53}. Data equals the prior cycle's FFTData_in. done pulses exactly one cycle after beat 1024.
- dim z pass, grp=1, k=2 gives addrs {516,517,518,519}. dim y pass, grp=4, k=3 gives addrs {304,305,306,307}.
- Drop FFTData_valid for 7 cycles mid-pass: wren=0 throughout, addresses resume exactly, done still follows beat 1024, err=0.
- Each of these sets err=1 and leaves state correct: start with FFT_dim=3 stays IDLE; start during RUN leaves the pass unaffected; valid in IDLE gives wren=0.
- Assert rst at beat 500, then restart with dim y: the first write goes to addrs {0,1,2,3} (k=0, grp=0), and busy and done behave as on a fresh pass.
- With FFT_WB_BITREV_EN, dim x beat k=1 gives addrs {8,24,40,56}; all 4096 addresses are written exactly once per pass (scoreboard check).

Source files
------------

// File: rtl/fft_writeback_ctrl_if.sv
// Bus between the FFT lanes / control source and the grid write-back controller.
// The controller takes the slave side; the source and the memory observe the master side.
interface fft_writeback_ctrl_if #(
  parameter int NUM_FFTS        = 4,
  parameter int DATA_REAL_WIDTH = 32,
  parameter int DATA_IMAG_WIDTH = 32,
  parameter int ADDR_WIDTH      = 12
);
  localparam int DATA_WIDTH = NUM_FFTS * (DATA_REAL_WIDTH + DATA_IMAG_WIDTH + 2);

  // Handshake: a beat is transferred on every cycle FFTData_valid is high (no ready, the
  // controller never stalls); a write is performed on every cycle a DATABASE_wren bit is high.
  logic                             start;
  logic [2:0]                       FFT_dim;
  logic                             FFTData_valid;
  logic [DATA_WIDTH-1:0]            FFTData_in;
  logic [NUM_FFTS-1:0]              DATABASE_wren;
  logic [NUM_FFTS*ADDR_WIDTH-1:0]   DATABASE_writeAddress;
  logic [DATA_WIDTH-1:0]            DATABASE_dataIn;
  logic                             busy;
  logic                             done;
  logic                             err;
  logic [1:0]                       fsm_state;

  modport master (
    output start, FFT_dim, FFTData_valid, FFTData_in,
    input  DATABASE_wren, DATABASE_writeAddress, DATABASE_dataIn, busy, done, err, fsm_state
  );

  modport slave (
    input  start, FFT_dim, FFTData_valid, FFTData_in,
    output DATABASE_wren, DATABASE_writeAddress, DATABASE_dataIn, busy, done, err, fsm_state
  );
endinterface

// File: rtl/fft_writeback_ctrl.sv
// Scatters NUM_FFTS parallel FFT result lanes back into the D^3 grid memory.
// Optional FFT_WB_BITREV_EN: sample index k is bit-reversed before address mapping.
module fft_writeback_ctrl #(
  parameter int DIMENSION       = 16,
  parameter int NUM_FFTS        = 4,
  parameter int DATA_REAL_WIDTH = 32,
  parameter int DATA_IMAG_WIDTH = 32,
  parameter int ADDR_WIDTH      = 3 * $clog2(DIMENSION)
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_writeback_ctrl_if.slave  bus
);
  localparam int LOG_D      = $clog2(DIMENSION);
  localparam int LINE_W     = 2 * LOG_D;
  localparam int GRP_W      = LINE_W - $clog2(NUM_FFTS);
  localparam int DATA_WIDTH = NUM_FFTS * (DATA_REAL_WIDTH + DATA_IMAG_WIDTH + 2);
  localparam logic [LOG_D-1:0] K_MAX   = LOG_D'(DIMENSION - 1);
  localparam logic [GRP_W-1:0] GRP_MAX = GRP_W'(DIMENSION * DIMENSION / NUM_FFTS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic [2:0]                      dim_q, dim_d;
  logic [LOG_D-1:0]                k_q, k_d;
  logic [GRP_W-1:0]                grp_q, grp_d;
  logic                            err_q, err_d;
  logic [NUM_FFTS-1:0]             wren_q, wren_d;
  logic [NUM_FFTS*ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]           data_q, data_d;

  logic [LOG_D-1:0]                k_eff;
  logic [LINE_W-1:0]               line;
  logic [LOG_D-1:0]                line_a;
  logic [LOG_D-1:0]                line_b;
  logic [NUM_FFTS*ADDR_WIDTH-1:0]  addr_calc;
  logic                            dim_ok;

  always_comb begin
    k_eff = k_q;
`ifdef FFT_WB_BITREV_EN
    for (int i = 0; i < LOG_D; i++) begin
      k_eff[i] = k_q[LOG_D-1-i];
    end
`endif
  end

  // Lane l writes line grp*NUM_FFTS+l; the line splits into the two non-transform axes.
  always_comb begin
    addr_calc = '0;
    line      = '0;
    line_a    = '0;
    line_b    = '0;
    for (int l = 0; l < NUM_FFTS; l++) begin
      line   = LINE_W'(grp_q) * LINE_W'(NUM_FFTS) + LINE_W'(l);
      line_a = line[LOG_D-1:0];
      line_b = line[LINE_W-1:LOG_D];
      if (dim_q[0]) begin
        addr_calc[l*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'({line_b, line_a, k_eff});
      end else if (dim_q[1]) begin
        addr_calc[l*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'({line_b, k_eff, line_a});
      end else begin
        addr_calc[l*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'({k_eff, line_b, line_a});
      end
    end
  end

  assign dim_ok = (bus.FFT_dim == 3'b001) || (bus.FFT_dim == 3'b010) || (bus.FFT_dim == 3'b100);

  always_comb begin
    state_d = state_q;
    dim_d   = dim_q;
    k_d     = k_q;
    grp_d   = grp_q;
    err_d   = err_q;
    wren_d  = '0;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.FFTData_valid) begin
          err_d = 1'b1;
        end
        if (bus.start) begin
          if (dim_ok) begin
            state_d = S_RUN;
            dim_d   = bus.FFT_dim;
            k_d     = '0;
            grp_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (bus.start) begin
          err_d = 1'b1;
        end
        if (bus.FFTData_valid) begin
          wren_d = '1;
          addr_d = addr_calc;
          data_d = bus.FFTData_in;
          k_d    = k_q + LOG_D'(1);
          if (k_q == K_MAX) begin
            grp_d = grp_q + GRP_W'(1);
            if (grp_q == GRP_MAX) begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        if (bus.start) begin
          err_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dim_q   <= '0;
      k_q     <= '0;
      grp_q   <= '0;
      err_q   <= 1'b0;
      wren_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      dim_q   <= dim_d;
      k_q     <= k_d;
      grp_q   <= grp_d;
      err_q   <= err_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign bus.DATABASE_wren         = wren_q;
  assign bus.DATABASE_writeAddress = addr_q;
  assign bus.DATABASE_dataIn       = data_q;
  assign bus.busy                  = (state_q != S_IDLE);
  assign bus.done                  = (state_q == S_DONE);
  assign bus.err                   = err_q;
  assign bus.fsm_state             = state_q;
endmodule

// File: tb/tb_fft_writeback_ctrl.sv
// Directed bench for fft_writeback_ctrl: address table, write scoreboard, and protocol corner cases.
// Expectations follow FFT_WB_BITREV_EN when it is defined for the build.
module tb_fft_writeback_ctrl;
  localparam int D     = 16;
  localparam int LD    = 4;
  localparam int N     = 4;
  localparam int RW    = 32;
  localparam int IW    = 32;
  localparam int AW    = 12;
  localparam int LW    = RW + IW + 2;
  localparam int DW    = N * LW;
  localparam int BEATS = D * D * D / N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_writeback_ctrl_if #(.NUM_FFTS(N), .DATA_REAL_WIDTH(RW), .DATA_IMAG_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

  fft_writeback_ctrl #(
    .DIMENSION(D), .NUM_FFTS(N), .DATA_REAL_WIDTH(RW), .DATA_IMAG_WIDTH(IW), .ADDR_WIDTH(AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]  dim;
    int          beat;
    int unsigned addr [N];
  } vec_t;

  vec_t              tbl [7];
  int                checks = 0;
  int                errors = 0;
  logic [N*AW-1:0]   exp_q [$];
  logic [DW-1:0]     dat_q [$];
  logic [N*AW-1:0]   wr_log [BEATS];
  int                wr_idx;
  int                wr_cnt [D*D*D];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*AW-1:0] model_addr(input logic [2:0] dim, input int beat);
    logic [N*AW-1:0] r;
    int k, grp, line, a, b, x, y, z;
    r   = '0;
    k   = beat % D;
    grp = beat / D;
`ifdef FFT_WB_BITREV_EN
    begin
      int kr;
      kr = 0;
      for (int i = 0; i < LD; i++) if ((k >> i) & 1) kr = kr | (1 << (LD - 1 - i));
      k = kr;
    end
`endif
    for (int l = 0; l < N; l++) begin
      line = grp * N + l;
      a = line % D;
      b = line / D;
      if (dim == 3'b001) begin x = k; y = a; z = b; end
      else if (dim == 3'b010) begin x = a; y = k; z = b; end
      else begin x = a; y = b; z = k; end
      r[l*AW +: AW] = AW'(x + y * D + z * D * D);
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic set_vec(input int i, input logic [2:0] dim, input int beat,
                         input int unsigned a0, input int unsigned a1,
                         input int unsigned a2, input int unsigned a3);
    tbl[i].dim     = dim;
    tbl[i].beat    = beat;
    tbl[i].addr[0] = a0;
    tbl[i].addr[1] = a1;
    tbl[i].addr[2] = a2;
    tbl[i].addr[3] = a3;
  endtask

  // Advance one clock and sample #1 later; any write seen is checked against the expected queue.
  task automatic tick();
    logic [N*AW-1:0] ea;
    logic [DW-1:0]   ed;
    @(posedge clk);
    #1;
    if (bus.DATABASE_wren !== '0) begin
      chk("wren_all_lanes", DW'(bus.DATABASE_wren), DW'({N{1'b1}}));
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h, expected no write", bus.DATABASE_writeAddress);
      end else begin
        ea = exp_q.pop_front();
        ed = dat_q.pop_front();
        chk("wr_addr", DW'(bus.DATABASE_writeAddress), DW'(ea));
        chk("wr_data", bus.DATABASE_dataIn, ed);
        if (wr_idx < BEATS) wr_log[wr_idx] = bus.DATABASE_writeAddress;
        wr_idx++;
        for (int l = 0; l < N; l++) wr_cnt[int'(bus.DATABASE_writeAddress[l*AW +: AW])]++;
      end
    end
    if (bus.done === 1'b1) chk("done_at_last_write", DW'(wr_idx), DW'(BEATS));
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    bus.start         = 1'b0;
    bus.FFT_dim       = 3'b000;
    bus.FFTData_valid = 1'b0;
    bus.FFTData_in    = '0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    dat_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wren"},  DW'(bus.DATABASE_wren), '0);
    chk({tag, "_addr"},  DW'(bus.DATABASE_writeAddress), '0);
    chk({tag, "_data"},  bus.DATABASE_dataIn, '0);
    chk({tag, "_busy"},  DW'(bus.busy), '0);
    chk({tag, "_done"},  DW'(bus.done), '0);
    chk({tag, "_err"},   DW'(bus.err), '0);
    chk({tag, "_state"}, DW'(bus.fsm_state), '0);
  endtask

  task automatic check_table(input logic [2:0] dim);
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].dim == dim) begin
        for (int l = 0; l < N; l++) begin
          chk("tbl_addr", DW'(wr_log[tbl[i].beat][l*AW +: AW]), DW'(tbl[i].addr[l]));
        end
      end
    end
  endtask

  task automatic run_pass(input logic [2:0] dim, input int gap_at, input int gap_len,
                          input int start_at, input int rst_at, input bit start_in_done);
    logic [DW-1:0] d;
    int bad;
    wr_idx = 0;
    for (int i = 0; i < D*D*D; i++) wr_cnt[i] = 0;
    bus.start   = 1'b1;
    bus.FFT_dim = dim;
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", DW'(bus.busy), DW'(1));
    for (int i = 0; i < BEATS; i++) begin
      if (i == rst_at) begin
        rst               = 1'b1;
        bus.FFTData_valid = 1'b1;
        bus.FFTData_in    = rand_data();
        tick();
        rst               = 1'b0;
        bus.FFTData_valid = 1'b0;
        chk_all_zero("mid_pass_rst");
        chk("mid_pass_rst_pending", DW'(exp_q.size()), '0);
        exp_q.delete();
        dat_q.delete();
        return;
      end
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          tick();
          chk("gap_wren", DW'(bus.DATABASE_wren), '0);
          chk("gap_busy", DW'(bus.busy), DW'(1));
        end
      end
      if (i == start_at) begin
        bus.start   = 1'b1;
        bus.FFT_dim = 3'b010;
      end
      d = rand_data();
      bus.FFTData_valid = 1'b1;
      bus.FFTData_in    = d;
      exp_q.push_back(model_addr(dim, i));
      dat_q.push_back(d);
      tick();
      bus.FFTData_valid = 1'b0;
      bus.start         = 1'b0;
      if (i == start_at) chk("err_start_in_run", DW'(bus.err), DW'(1));
    end
    chk("done_with_last_write", DW'(bus.done), DW'(1));
    chk("busy_with_last_write", DW'(bus.busy), DW'(1));
    if (start_in_done) begin
      bus.start   = 1'b1;
      bus.FFT_dim = 3'b001;
    end
    tick();
    bus.start = 1'b0;
    chk("done_one_cycle", DW'(bus.done), '0);
    chk("busy_low_after_done", DW'(bus.busy), '0);
    if (start_in_done) begin
      chk("err_start_in_done", DW'(bus.err), DW'(1));
      tick();
      chk("start_in_done_ignored", DW'(bus.busy), '0);
    end else if (start_at < 0) begin
      chk("err_clean_pass", DW'(bus.err), '0);
    end
    chk("pass_all_written", DW'(exp_q.size()), '0);
    bad = 0;
    for (int i = 0; i < D*D*D; i++) if (wr_cnt[i] != 1) bad++;
    chk("each_addr_once", DW'(bad), '0);
    check_table(dim);
  endtask

  initial begin
`ifdef FFT_WB_BITREV_EN
    set_vec(0, 3'b001, 0,    0, 16, 32, 48);
    set_vec(1, 3'b001, 5,    10, 26, 42, 58);
    set_vec(2, 3'b001, 1,    8, 24, 40, 56);
    set_vec(3, 3'b001, 1023, 4047, 4063, 4079, 4095);
    set_vec(4, 3'b100, 18,   1028, 1029, 1030, 1031);
    set_vec(5, 3'b010, 67,   448, 449, 450, 451);
    set_vec(6, 3'b010, 0,    0, 1, 2, 3);
`else
    set_vec(0, 3'b001, 0,    0, 16, 32, 48);
    set_vec(1, 3'b001, 5,    5, 21, 37, 53);
    set_vec(2, 3'b001, 1,    1, 17, 33, 49);
    set_vec(3, 3'b001, 1023, 4047, 4063, 4079, 4095);
    set_vec(4, 3'b100, 18,   516, 517, 518, 519);
    set_vec(5, 3'b010, 67,   304, 305, 306, 307);
    set_vec(6, 3'b010, 0,    0, 1, 2, 3);
`endif
    wr_idx = 0;
    do_reset();
    chk_all_zero("reset");

    run_pass(3'b001, 300, 7, -1, -1, 1'b0);
    run_pass(3'b100, -1, 0, -1, -1, 1'b0);
    run_pass(3'b001, -1, 0, 100, 500, 1'b0);
    run_pass(3'b010, -1, 0, -1, -1, 1'b1);

    do_reset();
    bus.start   = 1'b1;
    bus.FFT_dim = 3'b011;
    tick();
    bus.start = 1'b0;
    chk("bad_dim_err", DW'(bus.err), DW'(1));
    chk("bad_dim_idle", DW'(bus.fsm_state), '0);
    chk("bad_dim_busy", DW'(bus.busy), '0);

    do_reset();
    bus.FFTData_valid = 1'b1;
    bus.FFTData_in    = rand_data();
    tick();
    bus.FFTData_valid = 1'b0;
    chk("idle_valid_err", DW'(bus.err), DW'(1));
    chk("idle_valid_busy", DW'(bus.busy), '0);
    tick();
    chk("idle_valid_no_write", DW'(bus.DATABASE_wren), '0);

    do_reset();
    bus.start         = 1'b1;
    bus.FFT_dim       = 3'b100;
    bus.FFTData_valid = 1'b1;
    bus.FFTData_in    = rand_data();
    tick();
    bus.start         = 1'b0;
    bus.FFTData_valid = 1'b0;
    chk("start_valid_busy", DW'(bus.busy), DW'(1));
    chk("start_valid_err", DW'(bus.err), DW'(1));
    tick();
    chk("start_valid_dropped", DW'(bus.DATABASE_wren), '0);
    do_reset();
    chk_all_zero("final_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
